// File: rtl/lsu_subword_access.sv
// -----------------------------------------------------------------------------
// lsu_subword_access
//
// Load/store unit for the MEM stage. It sits between the CPU datapath and a
// word-wide data memory.
//   - Loads fetch the whole word, pick the addressed byte or half lane
//     (little-endian), and sign- or zero-extend the lane to 32 bits.
//   - Stores narrow the store data into the addressed lane. Without byte
//     strobes this is a read-modify-write (READ then WRITE). With strobes the
//     lane is written directly.
//   - Misaligned accesses and the illegal size return an error. They never
//     touch memory.
//   - A memory that does not ack within TIMEOUT cycles aborts the access
//     with an error.
//
// Optional feature macro: LSU_BYTE_STROBE_EN
//   Defining it adds the mem_be[3:0] lane-strobe output. Sub-word stores then
//   go straight to WRITE with req_wdata replicated across all lanes.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   req_*          request handshake (valid/ready) plus the access fields
//   resp_*         one-cycle completion pulse, error flag, extended load data
//   mem_*          word-wide memory port; the request is held until mem_ack
//   mem_be         lane strobes (only when LSU_BYTE_STROBE_EN is defined)
// -----------------------------------------------------------------------------
module lsu_subword_access #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsig,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
`ifdef LSU_BYTE_STROBE_EN
   output logic [3:0]        mem_be,
`endif
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Last count value at which the memory may still ack.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   // data_q holds the word being written, or the raw word returned by a load.
   logic [31:0]       data_q, data_d;
   logic              err_q, err_d;
   logic              we_q;
   logic [1:0]        size_q;
   logic              unsig_q;
   logic [ADDR_W-1:0] addr_q;
`ifdef LSU_BYTE_STROBE_EN
   logic [3:0]        be_q;
`else
   logic [15:0]       wdata_q;
`endif

   logic        accept;
   logic        req_bad;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_ext;

   assign accept = (state_q == IDLE) && req_valid;

   // Illegal size, or an access that is not naturally aligned.
   assign req_bad = (req_size == 2'b11)
                 || ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifndef LSU_BYTE_STROBE_EN
   // Replace the addressed lane of the old word; every other lane is kept.
   function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                              input logic [15:0] wd,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  a);
      logic [31:0] r;
      r = old_w;
      if (sz == SZ_BYTE) r[{a, 3'b000} +: 8] = wd[7:0];
      else               r[{a[1], 4'b0000} +: 16] = wd;
      return r;
   endfunction
`endif

   // NOTE: every signal written here gets a default first. Any path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               err_d = 1'b0;
               cnt_d = '0;
               if (req_bad) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else if (!req_we) begin
                  state_d = READ;
               end else if (req_size == SZ_WORD) begin
                  data_d  = req_wdata;
                  state_d = WRITE;
               end else begin
`ifdef LSU_BYTE_STROBE_EN
                  // The strobes pick the lane, so the data is replicated.
                  data_d  = (req_size == SZ_BYTE) ? {4{req_wdata[7:0]}}
                                                  : {2{req_wdata[15:0]}};
                  state_d = WRITE;
`else
                  state_d = READ;
`endif
               end
            end
         end
         READ: begin
            if (mem_ack) begin
`ifdef LSU_BYTE_STROBE_EN
               data_d  = mem_rdata;
               state_d = RESP;
`else
               if (we_q) begin
                  data_d  = merge_lane(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                  cnt_d   = '0;
                  state_d = WRITE;
               end else begin
                  data_d  = mem_rdata;
                  state_d = RESP;
               end
`endif
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         WRITE: begin
            if (mem_ack) begin
               state_d = RESP;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only. All flops
   // update together on the edge, so their evaluation order cannot matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         // NOTE: the datapath registers are reset too. mem_wdata, mem_addr
         // and resp_rdata are derived from them and must read 0 out of reset.
         data_q  <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         size_q  <= '0;
         unsig_q <= 1'b0;
         addr_q  <= '0;
`ifdef LSU_BYTE_STROBE_EN
         be_q    <= '0;
`else
         wdata_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            unsig_q <= req_unsig;
            addr_q  <= req_addr;
`ifdef LSU_BYTE_STROBE_EN
            if (req_we && (req_size == SZ_BYTE))
               be_q <= 4'b0001 << req_addr[1:0];
            else if (req_we && (req_size == SZ_HALF))
               be_q <= req_addr[1] ? 4'b1100 : 4'b0011;
            else
               be_q <= 4'b1111;
`else
            wdata_q <= req_wdata[15:0];
`endif
         end
      end
   end

   // Lane extraction and extension of the captured load word.
   always_comb begin
      lane_b = data_q[{addr_q[1:0], 3'b000} +: 8];
      lane_h = data_q[{addr_q[1], 4'b0000} +: 16];
      unique case (size_q)
         SZ_BYTE: load_ext = unsig_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
         SZ_HALF: load_ext = unsig_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: load_ext = data_q;
      endcase
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !err_q && !we_q) ? load_ext : 32'b0;

   // Decoded straight from state: an asynchronous reset drops mem_req at once.
   assign mem_req   = (state_q == READ) || (state_q == WRITE);
   assign mem_we    = (state_q == WRITE);
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = (state_q == WRITE) ? data_q : 32'b0;
`ifdef LSU_BYTE_STROBE_EN
   assign mem_be    = mem_req ? be_q : 4'b0000;
`endif

endmodule

// File: tb/tb_lsu_subword_access.sv
// -----------------------------------------------------------------------------
// tb_lsu_subword_access
//
// Testbench for lsu_subword_access, built with TIMEOUT=4.
//   - A behavioural memory answers requests after a chosen delay: random,
//     fixed, or never.
//   - A table of directed vectors covers the lane, extension and error rules.
//   - Hand-written sequences cover read-modify-write, latency, timeout and
//     reset in the middle of an access.
//   - Random transactions are compared against a reference model of memory
//     contents built from plain shift/mask arithmetic.
// -----------------------------------------------------------------------------
module tb_lsu_subword_access;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsig;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef LSU_BYTE_STROBE_EN
   logic [3:0]  mem_be;
`endif

   lsu_subword_access #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsig(req_unsig), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
`ifdef LSU_BYTE_STROBE_EN
      .mem_be(mem_be),
`endif
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- memory
   localparam int M_RANDOM = 0, M_FIXED = 1, M_NEVER = 2;
   logic [31:0] phys[16];
   int          mem_mode    = M_RANDOM;
   int          fixed_delay = 0;
   int          req_cycles  = 0;
   int          n_reads     = 0;
   int          n_writes    = 0;
   logic [3:0]  last_be     = '0;
   logic [31:0] last_wdata  = '0;
   logic [31:0] exp_mem_addr = '0;

   initial begin : responder
      int          delay_left;
      bit          new_req;
      logic [31:0] start_addr, start_wdata;
      logic [31:0] w;
      logic [3:0]  be;
      new_req    = 1'b1;
      delay_left = 0;
      mem_ack    = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (rst_n && mem_req) begin
            req_cycles++;
            if (new_req) begin
               delay_left  = (mem_mode == M_FIXED) ? fixed_delay : $urandom_range(0, 2);
               new_req     = 1'b0;
               start_addr  = mem_addr;
               start_wdata = mem_wdata;
               check("mem_addr", mem_addr, exp_mem_addr);
            end else begin
               check("mem_addr_stable", mem_addr, start_addr);
               check("mem_wdata_stable", mem_wdata, start_wdata);
            end
            if (mem_mode != M_NEVER && delay_left == 0) begin
               mem_ack = 1'b1;
               new_req = 1'b1;
               if (mem_we) begin
`ifdef LSU_BYTE_STROBE_EN
                  be = mem_be;
`else
                  be = 4'b1111;
`endif
                  w = phys[mem_addr[5:2]];
                  for (int i = 0; i < 4; i++)
                     if (be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                  phys[mem_addr[5:2]] = w;
                  last_be    = be;
                  last_wdata = mem_wdata;
                  n_writes++;
               end else begin
                  mem_rdata = phys[mem_addr[5:2]];
                  n_reads++;
               end
            end else begin
               delay_left--;
            end
         end else begin
            new_req = 1'b1;
         end
      end
   end

   // ------------------------------------------------------- reference model
   function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                            input bit uns, input logic [31:0] a);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (word >> (8 * (a % 4))) & 32'hFF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [31:0] wd, input logic [31:0] a);
      logic [31:0] mask;
      int          sh;
      mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      sh   = (sz == 2'd0) ? 8 * (a % 4) : (sz == 2'd1) ? 16 * ((a / 2) % 2) : 0;
      return (word & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   // --------------------------------------------------------------- driver
   // lat counts negedges after the accepting edge until resp_valid is seen.
   task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output bit err, output logic [31:0] rd, output int lat);
      bit got;
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      exp_mem_addr = {a[31:2], 2'b00};
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsig = uns;
      req_addr  = a;    req_wdata = wd;
      got = 1'b0; err = 1'b1; rd = 'x; lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            // Fields are don't-care after acceptance: scramble them.
            req_valid = 1'b0; req_we = $urandom; req_size = $urandom;
            req_unsig = $urandom; req_addr = $urandom; req_wdata = $urandom;
         end
         if (resp_valid) begin
            got = 1'b1; err = resp_err; rd = resp_rdata; lat = k;
            break;
         end
      end
      check("resp_seen", 32'(got), 32'd1);
      @(negedge clk);
      check("resp_one_pulse", 32'(resp_valid), 32'd0);
   endtask

   typedef struct {
      bit          we;
      logic [1:0]  size;
      bit          unsig;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init_word;
      bit          exp_err;
      logic [31:0] exp_rdata;
      logic [31:0] exp_word;
   } vec_t;

   initial begin : main
      vec_t        vecs[$];
      bit          err;
      logic [31:0] rd;
      int          lat, rc0, idx;
      bit          we, uns;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp_rd;
      bit          exp_e;
      logic [31:0] ref_mem[16];

      vecs.push_back('{0, 2'd0, 0, 32'h03, 32'h0,        32'h80AA55CC, 0, 32'hFFFFFF80, 32'h80AA55CC});
      vecs.push_back('{0, 2'd1, 1, 32'h02, 32'h0,        32'h80011234, 0, 32'h00008001, 32'h80011234});
      vecs.push_back('{1, 2'd0, 0, 32'h01, 32'hABCDEFEE, 32'h11223344, 0, 32'h0,        32'h1122EE44});
      vecs.push_back('{0, 2'd2, 0, 32'h02, 32'h0,        32'h01020304, 1, 32'h0,        32'h01020304});
      vecs.push_back('{0, 2'd3, 0, 32'h04, 32'h0,        32'h01020304, 1, 32'h0,        32'h01020304});
      vecs.push_back('{0, 2'd0, 1, 32'h05, 32'h0,        32'h80AA55CC, 0, 32'h00000055, 32'h80AA55CC});
      vecs.push_back('{0, 2'd0, 0, 32'h04, 32'h0,        32'h80AA55CC, 0, 32'hFFFFFFCC, 32'h80AA55CC});
      vecs.push_back('{0, 2'd1, 0, 32'h08, 32'h0,        32'h0000F00D, 0, 32'hFFFFF00D, 32'h0000F00D});
      vecs.push_back('{0, 2'd1, 0, 32'h09, 32'h0,        32'h0000F00D, 1, 32'h0,        32'h0000F00D});
      vecs.push_back('{1, 2'd1, 0, 32'h0E, 32'h1234BEEF, 32'hAAAAAAAA, 0, 32'h0,        32'hBEEFAAAA});
      vecs.push_back('{1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h00000000, 0, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{1, 2'd2, 0, 32'h11, 32'hDEADBEEF, 32'h55555555, 1, 32'h0,        32'h55555555});
      vecs.push_back('{0, 2'd2, 1, 32'h14, 32'h0,        32'h12345678, 0, 32'h12345678, 32'h12345678});
      vecs.push_back('{1, 2'd3, 0, 32'h18, 32'hFFFFFFFF, 32'h77777777, 1, 32'h0,        32'h77777777});

      for (int i = 0; i < 16; i++) phys[i] = $urandom;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
      req_unsig = 1'b0; req_addr = '0; req_wdata = '0;

      // ---- reset state
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- directed vectors
      foreach (vecs[i]) begin
         idx = int'(vecs[i].addr[5:2]);
         phys[idx] = vecs[i].init_word;
         rc0 = req_cycles;
         do_req(vecs[i].we, vecs[i].size, vecs[i].unsig, vecs[i].addr, vecs[i].wdata, err, rd, lat);
         check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_word", i), phys[idx], vecs[i].exp_word);
         if (vecs[i].exp_err) begin
            check($sformatf("vec%0d_err_latency", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d_no_mem_req", i), 32'(req_cycles - rc0), 32'd0);
         end
      end

      // ---- sb: read-modify-write, or a single strobed write
      phys[0] = 32'h11223344;
      n_reads = 0; n_writes = 0;
      do_req(1'b1, 2'd0, 1'b0, 32'h01, 32'h000000EE, err, rd, lat);
`ifdef LSU_BYTE_STROBE_EN
      check("sb_reads", 32'(n_reads), 32'd0);
      check("sb_be", 32'(last_be), 32'b0010);
`else
      check("sb_reads", 32'(n_reads), 32'd1);
      check("sb_write_word", last_wdata, 32'h1122EE44);
`endif
      check("sb_writes", 32'(n_writes), 32'd1);
      check("sb_result", phys[0], 32'h1122EE44);

      // ---- load latency with a 1-cycle-ack memory
      mem_mode = M_FIXED; fixed_delay = 0;
      phys[3] = 32'hCAFE0080;
      do_req(1'b0, 2'd0, 1'b0, 32'h0C, 32'h0, err, rd, lat);
      check("lat_value", rd, 32'hFFFFFF80);
      check("lat_cycles", 32'(lat), 32'd2);

      // ---- timeout: no ack for TIMEOUT cycles
      mem_mode = M_NEVER;
      rc0 = req_cycles;
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, err, rd, lat);
      check("to_err", 32'(err), 32'd1);
      check("to_rdata", rd, 32'd0);
      check("to_req_cycles", 32'(req_cycles - rc0), 32'(TO));
      check("to_mem_req_low", 32'(mem_req), 32'd0);

      // ---- ack in the last allowed cycle wins over the timeout
      mem_mode = M_FIXED; fixed_delay = TO - 1;
      phys[8] = 32'h0BADF00D;
      rc0 = req_cycles;
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, err, rd, lat);
      check("late_ack_err", 32'(err), 32'd0);
      check("late_ack_rdata", rd, 32'h0BADF00D);
      check("late_ack_cycles", 32'(req_cycles - rc0), 32'(TO));

      // ---- reset pulsed in the middle of a WRITE
      mem_mode = M_NEVER;
      @(negedge clk);
      exp_mem_addr = 32'h24;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h24;
      req_wdata = 32'h13579BDF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rw_mem_req_before", 32'(mem_req), 32'd1);
      check("rw_mem_we_before", 32'(mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("rw_mem_req_dropped", 32'(mem_req), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("rw_no_resp_in_reset", 32'(resp_valid), 32'd0);
      end
      rst_n = 1'b1;
      mem_mode = M_RANDOM;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rw_no_resp_after", 32'(resp_valid), 32'd0);
         check("rw_ready_after", 32'(req_ready), 32'd1);
      end

      // ---- random traffic against the reference model
      for (int i = 0; i < 16; i++) ref_mem[i] = phys[i];
      for (int t = 0; t < 300; t++) begin
         we  = $urandom_range(0, 1);
         sz  = 2'($urandom_range(0, 3));
         uns = $urandom_range(0, 1);
         a   = $urandom_range(0, 63);
         wd  = $urandom;
         idx = int'(a / 4);
         exp_e  = ref_err(sz, a);
         exp_rd = (exp_e || we) ? 32'd0 : ref_load(ref_mem[idx], sz, uns, a);
         if (!exp_e && we) ref_mem[idx] = ref_store(ref_mem[idx], sz, wd, a);
         do_req(we, sz, uns, a, wd, err, rd, lat);
         check($sformatf("rnd%0d_err", t), 32'(err), 32'(exp_e));
         check($sformatf("rnd%0d_rdata", t), rd, exp_rd);
         check($sformatf("rnd%0d_word", t), phys[idx], ref_mem[idx]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
